// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Same-cycle lookup for IF, training from resolved branches in MEM, plus branch/mispredict statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       fetch_pc,
  input  logic              pred_en,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic              flush_tbl,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [STAT_W-1:0]   STAT_MAX = '1;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
  logic [STAT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             unused_pc_lsbs;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^upd_pc[1:0];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup sees registered table state only; updates land after the edge.
  assign pred_taken  = pred_en && f_hit && ctr_q[f_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid) begin
      if (branch_cnt_q != STAT_MAX) branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if ((upd_taken != upd_pred_taken) && (mispred_cnt_q != STAT_MAX))
        mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != CTR_MAX) ctr_d[u_idx] = ctr_q[u_idx] + CTR_BITS'(1);
          target_d[u_idx] = upd_target;
        end else if (ctr_q[u_idx] != '0) begin
          ctr_d[u_idx] = ctr_q[u_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = CTR_WEAK;
      end
    end
    // Flush overrides any allocation made in the same cycle.
    if (flush_tbl) valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q       <= '0;
      ctr_q         <= '{default: '0};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tags and targets are gated by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule
